// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
//
// Streams a program byte by byte into an instruction memory. A start request
// with a byte count either rejects the load (too long), completes at once
// (zero length) or opens a LOAD window. In that window each byte offered on
// InData/InValid is accepted and written one cycle later to the next
// sequential address. A running byte count and a modulo-256 checksum are
// kept. Byte i lands at address i, so a word read at address a returns
// {byte a, a+1, a+2, a+3} (big-endian).
//
// Parameters
//   DEPTH    instruction memory size in bytes
//   LENW     width of the byte-count fields (at most 32)
//
// Ports
//   clk      rising-edge clock for all state
//   rst_n    synchronous active-low reset
//   start    single-cycle load request, honoured in IDLE, DONE or ERR
//   abort    cancels a load in progress (ignored outside LOAD)
//   len      number of bytes to load, sampled when start is accepted
//   InData   incoming program byte
//   InValid  InData is valid
//   InReady  loader accepts a byte this cycle (combinational, state==LOAD)
//   WEn      byte write strobe to the instruction memory
//   WAdrs    byte write address
//   WData    byte write data
//   busy     load in progress; used as the CPU fetch hold
//   done     last load completed successfully
//   err      last request was rejected
//   ByteCnt  bytes accepted in the current or last load
//   ChkSum   modulo-256 sum of the accepted bytes
// -----------------------------------------------------------------------------
module imem_loader #(
  parameter int DEPTH = 400,
  parameter int LENW  = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            abort,
  input  logic [LENW-1:0] len,
  input  logic [7:0]      InData,
  input  logic            InValid,
  output logic            InReady,
  output logic            WEn,
  output logic [31:0]     WAdrs,
  output logic [7:0]      WData,
  output logic            busy,
  output logic            done,
  output logic            err,
  output logic [LENW-1:0] ByteCnt,
  output logic [7:0]      ChkSum
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam logic [1:0] S_ERR  = 2'd3;

  localparam logic [31:0] DEPTH_W = 32'(DEPTH);

  logic [1:0]      state_q, state_d;
  logic            wen_q, wen_d;
  logic [31:0]     wadrs_q, wadrs_d;
  logic [7:0]      wdata_q, wdata_d;
  logic [LENW-1:0] cnt_q, cnt_d;
  logic [7:0]      sum_q, sum_d;
  logic [LENW-1:0] len_q, len_d;

  logic [LENW-1:0] cnt_inc;
  logic [31:0]     len_ext;

  assign cnt_inc = cnt_q + LENW'(1);
  assign len_ext = 32'(len);

  always_comb begin
    state_d = state_q;
    wen_d   = 1'b0;
    wadrs_d = wadrs_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    len_d   = len_q;

    case (state_q)
      S_LOAD: begin
        // abort beats a byte offered in the same cycle: nothing is written
        // and the count/checksum keep their values.
        if (abort) begin
          state_d = S_IDLE;
        end else if (InValid) begin
          wen_d   = 1'b1;
          wadrs_d = 32'(cnt_q);
          wdata_d = InData;
          cnt_d   = cnt_inc;
          sum_d   = sum_q + InData;
          // Since len never exceeds DEPTH, cnt_q stays below DEPTH here and
          // the write address can never run off the end of the memory.
          if (cnt_inc == len_q) begin
            state_d = S_DONE;
          end
        end
      end
      default: begin
        // IDLE, DONE and ERR all accept a new request; abort is irrelevant.
        if (start) begin
          cnt_d = '0;
          sum_d = '0;
          len_d = len;
          if (len_ext > DEPTH_W) begin
            state_d = S_ERR;
          end else if (len == '0) begin
            state_d = S_DONE;
          end else begin
            state_d = S_LOAD;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      wen_q   <= 1'b0;
      wadrs_q <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
      sum_q   <= '0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      wen_q   <= wen_d;
      wadrs_q <= wadrs_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      len_q   <= len_d;
    end
  end

  assign InReady = (state_q == S_LOAD);
  assign busy    = (state_q == S_LOAD);
  assign done    = (state_q == S_DONE);
  assign err     = (state_q == S_ERR);
  assign WEn     = wen_q;
  assign WAdrs   = wadrs_q;
  assign WData   = wdata_q;
  assign ByteCnt = cnt_q;
  assign ChkSum  = sum_q;

endmodule

// File: tb/tb_imem_loader.sv
// -----------------------------------------------------------------------------
// tb_imem_loader
//
// Scoreboarded bench for imem_loader. The stimulus task advances a
// behavioural model of the loader (flags, byte count, checksum) and pushes
// every expected memory write, tagged with the cycle it must appear in, into
// a queue. An independent monitor pops that queue whenever WEn is seen.
// -----------------------------------------------------------------------------
module tb_imem_loader;

  localparam int DEPTH = 400;
  localparam int LENW  = 16;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic            abort = 1'b0;
  logic [LENW-1:0] len = '0;
  logic [7:0]      InData = '0;
  logic            InValid = 1'b0;
  logic            InReady;
  logic            WEn;
  logic [31:0]     WAdrs;
  logic [7:0]      WData;
  logic            busy;
  logic            done;
  logic            err;
  logic [LENW-1:0] ByteCnt;
  logic [7:0]      ChkSum;

  imem_loader #(.DEPTH(DEPTH), .LENW(LENW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .len(len),
    .InData(InData), .InValid(InValid), .InReady(InReady), .WEn(WEn),
    .WAdrs(WAdrs), .WData(WData), .busy(busy), .done(done), .err(err),
    .ByteCnt(ByteCnt), .ChkSum(ChkSum)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [31:0] a;
    logic [7:0]  d;
  } wr_t;

  wr_t wq[$];
  wr_t mon_w;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference model of the loader's observable state.
  logic       m_load = 1'b0;
  logic       m_done = 1'b0;
  logic       m_err  = 1'b0;
  int         m_cnt  = 0;
  int         m_len  = 0;
  logic [7:0] m_sum  = 8'h00;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // One clock cycle: apply inputs, advance the model, clock, check status.
  task automatic step(input logic s, input logic ab, input logic rn,
                      input logic [LENW-1:0] l, input logic v, input logic [7:0] d);
    start = s; abort = ab; rst_n = rn; len = l; InValid = v; InData = d;
    if (!rn) begin
      m_load = 0; m_done = 0; m_err = 0; m_cnt = 0; m_sum = 8'h00;
    end else if (!m_load) begin
      if (s) begin
        m_cnt = 0; m_sum = 8'h00; m_len = int'(l); m_done = 0; m_err = 0;
        if (int'(l) > DEPTH) m_err = 1;
        else if (l == 0)     m_done = 1;
        else                 m_load = 1;
      end
    end else if (ab) begin
      m_load = 0;
    end else if (v) begin
      wq.push_back('{cyc + 1, 32'(m_cnt), d});
      m_cnt++;
      m_sum = m_sum + d;
      if (m_cnt == m_len) begin
        m_load = 0; m_done = 1;
      end
    end
    @(posedge clk);
    cyc++;
    #1;
    chk("InReady", 32'(InReady), 32'(m_load));
    chk("busy",    32'(busy),    32'(m_load));
    chk("done",    32'(done),    32'(m_done));
    chk("err",     32'(err),     32'(m_err));
    chk("ByteCnt", 32'(ByteCnt), 32'(m_cnt));
    chk("ChkSum",  32'(ChkSum),  32'(m_sum));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 1, '0, 0, 8'h00);
  endtask

  // Write monitor: every WEn must match the oldest expected write and
  // appear in exactly the cycle after its accept.
  always @(negedge clk) begin
    if (WEn) begin
      if (wq.size() == 0) begin
        chk("wen_unexpected", 32'(WEn), 32'd0);
      end else begin
        mon_w = wq.pop_front();
        chk("wen_cycle", 32'(cyc), 32'(mon_w.due));
        chk("WAdrs", WAdrs, mon_w.a);
        chk("WData", 32'(WData), 32'(mon_w.d));
      end
      chk("wadrs_bound", 32'(WAdrs < DEPTH), 32'd1);
    end else if (wq.size() != 0 && wq[0].due <= cyc) begin
      mon_w = wq.pop_front();
      chk("wen_missing", 32'(WEn), 32'd1);
    end
  end

  logic [7:0] basic [4] = '{8'h20, 8'h08, 8'h00, 8'h05};

  initial begin
    // Reset state
    step(0, 0, 0, '0, 0, 8'h00);
    step(0, 0, 0, '0, 0, 8'h00);
    chk("rst_WEn",   32'(WEn), 32'd0);
    chk("rst_WAdrs", WAdrs, 32'd0);
    chk("rst_WData", 32'(WData), 32'd0);
    idle(1);

    // Basic load of four bytes
    step(1, 0, 1, 16'd4, 0, 8'h00);
    for (int i = 0; i < 4; i++) step(0, 0, 1, '0, 1, basic[i]);
    idle(2);
    chk("basic_done", 32'(done), 32'd1);
    chk("basic_cnt",  32'(ByteCnt), 32'd4);
    chk("basic_sum",  32'(ChkSum), 32'h2D);

    // Gaps in InValid
    step(1, 0, 1, 16'd3, 0, 8'h00);
    for (int i = 0; i < 5; i++) step(0, 0, 1, '0, ((i % 2) == 0), 8'($urandom));
    idle(2);

    // Oversized request, then a zero-length one
    step(1, 0, 1, 16'd401, 0, 8'h00);
    for (int i = 0; i < 3; i++) step(0, 0, 1, '0, 1, 8'($urandom));
    chk("oversize_err", 32'(err), 32'd1);
    step(1, 0, 1, 16'd0, 1, 8'h11);
    chk("zero_done", 32'(done), 32'd1);
    idle(2);

    // Abort together with the third accept
    step(1, 0, 1, 16'd8, 0, 8'h00);
    step(0, 0, 1, '0, 1, 8'hA1);
    step(0, 0, 1, '0, 1, 8'hA2);
    step(0, 1, 1, '0, 1, 8'hA3);
    chk("abort_cnt",   32'(ByteCnt), 32'd2);
    chk("abort_ready", 32'(InReady), 32'd0);
    chk("abort_wen",   32'(WEn), 32'd0);
    idle(2);

    // Reset in the middle of a load
    step(1, 0, 1, 16'd10, 0, 8'h00);
    for (int i = 0; i < 5; i++) step(0, 0, 1, '0, 1, 8'(i + 8'h40));
    step(0, 0, 0, '0, 1, 8'h77);
    chk("midrst_WEn",   32'(WEn), 32'd0);
    chk("midrst_WAdrs", WAdrs, 32'd0);
    chk("midrst_WData", 32'(WData), 32'd0);
    step(1, 0, 1, 16'd2, 0, 8'h00);
    step(0, 0, 1, '0, 1, 8'hC3);
    step(0, 0, 1, '0, 1, 8'h3C);
    idle(2);

    // Fill the whole memory
    step(1, 0, 1, 16'(DEPTH), 0, 8'h00);
    for (int i = 0; i < DEPTH; i++) step(0, 0, 1, '0, 1, 8'(i & 8'hFF));
    idle(2);
    chk("full_done", 32'(done), 32'd1);
    chk("full_cnt",  32'(ByteCnt), 32'(DEPTH));

    // Randomized loads with gaps, stray starts and occasional aborts
    for (int k = 0; k < 30; k++) begin
      logic [LENW-1:0] l;
      l = ($urandom_range(0, 9) == 0) ? 16'($urandom_range(401, 1000))
                                      : 16'($urandom_range(0, 30));
      step(1, 1'($urandom_range(0, 1)), 1, l, 1'($urandom_range(0, 1)), 8'($urandom));
      for (int c = 0; c < 200 && m_load; c++) begin
        step(1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 40) == 0), 1,
             16'($urandom_range(0, 500)), 1'($urandom_range(0, 2) != 0), 8'($urandom));
      end
      step(0, 1'($urandom_range(0, 1)), 1, '0, 1'($urandom_range(0, 1)), 8'($urandom));
    end

    idle(3);
    chk("writes_drained", 32'(wq.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 The block SHALL have parameter DEPTH, default 400, giving the instruction memory size in bytes.
REQ-002 The block SHALL have parameter LENW, default 16, giving the width of the byte-count fields.
REQ-003 The block SHALL have one clock; reset is synchronous and active-low.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst_n  input  1  synchronous active-low reset.
REQ-006 start  input  1  single-cycle load request; sampled only in IDLE, DONE or ERR.
REQ-007 abort  input  1  cancels an in-progress load.
REQ-008 len  input  LENW  number of bytes to load; sampled on the cycle start is accepted.
REQ-009 InData  input  8  incoming program byte.
REQ-010 InValid  input  1  InData is valid.
REQ-011 InReady  output  1  loader accepts a byte this cycle.
REQ-012 WEn  output  1  byte write strobe to the instruction memory.
REQ-013 WAdrs  output  32  byte write address.
REQ-014 WData  output  8  byte write data.
REQ-015 busy  output  1  a load is in progress.
REQ-016 done  output  1  the last load completed successfully.
REQ-017 err  output  1  the last request was rejected.
REQ-018 ByteCnt  output  LENW  number of bytes accepted in the current or last load.
REQ-019 ChkSum  output  8  modulo-256 sum of the bytes accepted.

Function
REQ-020 The FSM SHALL have four states: IDLE, LOAD, DONE, ERR.
REQ-021 From IDLE, DONE or ERR, start=1 SHALL clear ByteCnt and ChkSum and then select the next state by len:
- len > DEPTH -> ERR;
- len = 0 -> DONE;
- otherwise -> LOAD.
REQ-022 start SHALL be ignored while in LOAD.
REQ-023 InReady SHALL be a combinational output, equal to 1 exactly when the state is LOAD.
REQ-024 A byte SHALL be accepted on a rising edge where InValid=1 and InReady=1; InValid while InReady=0 SHALL have no effect.
REQ-025 On each accepted byte the block SHALL register, effective the next cycle:
- WEn=1;
- WAdrs = ByteCnt, zero-extended;
- WData = InData;
- ByteCnt = ByteCnt+1;
- ChkSum = ChkSum+InData, modulo 256.
REQ-026 WEn SHALL be 0 in every cycle that does not follow an accept, giving write latency exactly one cycle after the accept.
REQ-027 Byte i of the stream SHALL be written to address i, so that a word read at address a returns {byte a, a+1, a+2, a+3} (big-endian).
REQ-028 When the accepted byte makes ByteCnt+1 equal len, the state SHALL go to DONE on that edge; InReady SHALL be 0 from the next cycle.
REQ-029 The final WEn pulse SHALL occur in the first DONE cycle.
REQ-030 busy SHALL equal (state==LOAD), and SHALL be used as the CPU fetch hold.
REQ-031 done SHALL be 1 only in DONE; err SHALL be 1 only in ERR; both SHALL be held until the next accepted start.
REQ-032 abort=1 in LOAD SHALL return the FSM to IDLE on that edge.
REQ-033 If a byte is accepted in the same cycle as abort, abort SHALL win: no write, and ByteCnt and ChkSum are unchanged.
REQ-034 After abort, ByteCnt and ChkSum SHALL retain their values, and WEn SHALL be 0 the next cycle.
REQ-035 abort outside LOAD SHALL be ignored.
REQ-036 If start and abort are both 1 in IDLE, DONE or ERR, start SHALL take effect.
REQ-037 WAdrs SHALL never reach DEPTH or above.

Reset
REQ-038 When rst_n=0 at a rising edge, the block SHALL go to IDLE and set WEn=0, WAdrs=0, WData=0, ByteCnt=0, ChkSum=0, done=0, err=0; InReady=0 and busy=0 then follow from IDLE.
REQ-039 Reset asserted mid-load SHALL drop the load with no further WEn pulse.
REQ-040 rst_n SHALL have priority over start and abort.

Verification
REQ-041 Basic load: start, len=4, bytes 0x20,0x08,0x00,0x05 with InValid held high -> writes at addresses 0..3 in consecutive cycles, each 1 cycle after its accept; done=1; ByteCnt=4; ChkSum=0x2D.
REQ-042 Backpressure gaps: len=3 with InValid toggling 1,0,1,0,1 -> exactly 3 WEn pulses at addresses 0,1,2; no pulse in the gap cycles.
REQ-043 Bounds: len=401 -> err=1, InReady never 1, no WEn; then len=0 -> done=1 in the cycle after start, with no WEn.
REQ-044 Abort: len=8, abort asserted together with the 3rd accept -> 2 writes only, FSM in IDLE, ByteCnt=2, InReady=0 the next cycle.
REQ-045 Reset mid-load: rst_n=0 after 5 of 10 bytes -> all outputs at reset values the next cycle; a following start with len=2 writes addresses 0 and 1.
REQ-046 Full memory: len=400, bytes i&0xFF -> last write at WAdrs=399, done=1, ByteCnt=400, ChkSum equal to the modulo-256 sum of the bytes.
